// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes in RISC-V
// funct3 order, FSM state constants and width helpers.
package muldiv_pkg;

   localparam logic [2:0] OP_MUL    = 3'd0;
   localparam logic [2:0] OP_MULH   = 3'd1;
   localparam logic [2:0] OP_MULHSU = 3'd2;
   localparam logic [2:0] OP_MULHU  = 3'd3;
   localparam logic [2:0] OP_DIV    = 3'd4;
   localparam logic [2:0] OP_DIVU   = 3'd5;
   localparam logic [2:0] OP_REM    = 3'd6;
   localparam logic [2:0] OP_REMU   = 3'd7;

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_RESP = 3'd4;

   // CNT_W for a given operand width: enough bits to hold the value xlen.
   function automatic int cnt_w(input int xlen);
      return $clog2(xlen + 1);
   endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, MSB first, XLEN cycles
// after start. done is high during the cycle that produces the last bit.
module muldiv_div_core
   import muldiv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            start,
   input  logic            abort,
   input  logic [XLEN-1:0] dividend,
   input  logic [XLEN-1:0] divisor,
   output logic [XLEN-1:0] quotient,
   output logic [XLEN-1:0] remainder,
   output logic            done
);

   localparam int CNT_W = cnt_w(XLEN);

   logic [XLEN:0]   rem_q, rem_d;
   logic [XLEN-1:0] quo_q, quo_d;
   logic [XLEN-1:0] dvs_q, dvs_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic            run_q, run_d;
   logic [XLEN+1:0] shifted;
   logic [XLEN+1:0] diff;

   always_comb begin
      rem_d   = rem_q;
      quo_d   = quo_q;
      dvs_d   = dvs_q;
      cnt_d   = cnt_q;
      run_d   = run_q;
      // Quotient register doubles as the dividend shift register.
      shifted = {rem_q, quo_q[XLEN-1]};
      diff    = shifted - {2'b00, dvs_q};
      if (abort) begin
         run_d = 1'b0;
      end else if (start) begin
         rem_d = '0;
         quo_d = dividend;
         dvs_d = divisor;
         cnt_d = CNT_W'(XLEN);
         run_d = 1'b1;
      end else if (run_q) begin
         if (!diff[XLEN+1]) begin
            rem_d = diff[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_d = shifted[XLEN:0];
            quo_d = {quo_q[XLEN-2:0], 1'b0};
         end
         cnt_d = cnt_q - CNT_W'(1);
         if (cnt_q == CNT_W'(1)) run_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q <= '0;
         quo_q <= '0;
         dvs_q <= '0;
         cnt_q <= '0;
         run_q <= 1'b0;
      end else begin
         rem_q <= rem_d;
         quo_q <= quo_d;
         dvs_q <= dvs_d;
         cnt_q <= cnt_d;
         run_q <= run_d;
      end
   end

   assign quotient  = quo_q;
   assign remainder = rem_q[XLEN-1:0];
   assign done      = run_q && (cnt_q == CNT_W'(1));

endmodule

// File: rtl/muldiv_iter_unit.sv
// Per-hart multiply/divide unit: pipelined-latency multiplier, iterative divider,
// valid/ready on request and response, and per-hart flush of the in-flight op.
module muldiv_iter_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int HART_ID_W   = 2,
   parameter int REG_ADDR_W  = 5,
   parameter int MUL_LATENCY = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_op,
   input  logic [XLEN-1:0]       req_a,
   input  logic [XLEN-1:0]       req_b,
   input  logic [HART_ID_W-1:0]  req_hart_id,
   input  logic [REG_ADDR_W-1:0] req_rd,
   input  logic                  flush_valid,
   input  logic [HART_ID_W-1:0]  flush_hart_id,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [XLEN-1:0]       rsp_result,
   output logic [HART_ID_W-1:0]  rsp_hart_id,
   output logic [REG_ADDR_W-1:0] rsp_rd,
   output logic                  busy
);

   localparam logic [XLEN-1:0] SIGN_MIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [XLEN-1:0] ALL_ONES = '1;
   localparam int MCNT_W = $clog2(MUL_LATENCY + 1);

   logic [2:0]            state_q, state_d;
   logic [2:0]            op_q, op_d;
   logic [HART_ID_W-1:0]  hart_q, hart_d;
   logic [REG_ADDR_W-1:0] rd_q, rd_d;
   logic [MCNT_W-1:0]     cnt_q, cnt_d;
   logic [2*XLEN-1:0]     prod_q, prod_d;
   logic                  qneg_q, qneg_d, rneg_q, rneg_d;
   logic [XLEN-1:0]       result_q, result_d;

   logic                  accept, flush_hit, div_start, div_done;
   logic                  a_sx, b_sx, is_sgn_div, a_neg, b_neg;
   logic signed [2*XLEN-1:0] a_w, b_w, prod_full;
   logic [XLEN-1:0]       mag_a, mag_b, div_quo, div_rem;

   function automatic logic [XLEN-1:0] mul_sel(input logic [2:0] op,
                                               input logic [2*XLEN-1:0] prod);
      return (op == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
   endfunction

   // Operands are widened to 2*XLEN so the low half of one multiply covers all four ops.
   always_comb begin
      a_sx       = (req_op == OP_MULH || req_op == OP_MULHSU) && req_a[XLEN-1];
      b_sx       = (req_op == OP_MULH) && req_b[XLEN-1];
      a_w        = {{XLEN{a_sx}}, req_a};
      b_w        = {{XLEN{b_sx}}, req_b};
      prod_full  = a_w * b_w;
      is_sgn_div = !req_op[0];
      a_neg      = is_sgn_div && req_a[XLEN-1];
      b_neg      = is_sgn_div && req_b[XLEN-1];
      mag_a      = a_neg ? -req_a : req_a;
      mag_b      = b_neg ? -req_b : req_b;
   end

   assign accept    = req_valid && (state_q == ST_IDLE) &&
                      !(flush_valid && flush_hart_id == req_hart_id);
   assign flush_hit = flush_valid && (flush_hart_id == hart_q);

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      hart_d    = hart_q;
      rd_d      = rd_q;
      cnt_d     = cnt_q;
      prod_d    = prod_q;
      qneg_d    = qneg_q;
      rneg_d    = rneg_q;
      result_d  = result_q;
      div_start = 1'b0;
      case (state_q)
         ST_IDLE: if (accept) begin
            op_d   = req_op;
            hart_d = req_hart_id;
            rd_d   = req_rd;
            if (!req_op[2]) begin
               prod_d = prod_full;
               if (MUL_LATENCY == 1) begin
                  result_d = mul_sel(req_op, prod_full);
                  state_d  = ST_RESP;
               end else begin
                  cnt_d   = MCNT_W'(MUL_LATENCY - 1);
                  state_d = ST_MUL;
               end
            end else if (req_b == '0) begin
               result_d = req_op[1] ? req_a : ALL_ONES;
               state_d  = ST_RESP;
            end else if (is_sgn_div && req_a == SIGN_MIN && req_b == ALL_ONES) begin
               result_d = req_op[1] ? '0 : req_a;
               state_d  = ST_RESP;
            end else begin
               qneg_d    = a_neg ^ b_neg;
               rneg_d    = a_neg;
               div_start = 1'b1;
               state_d   = ST_DIV;
            end
         end
         ST_MUL: if (flush_hit) begin
            state_d = ST_IDLE;
         end else if (cnt_q == MCNT_W'(1)) begin
            result_d = mul_sel(op_q, prod_q);
            state_d  = ST_RESP;
         end else begin
            cnt_d = cnt_q - MCNT_W'(1);
         end
         ST_DIV: if (flush_hit) state_d = ST_IDLE;
                 else if (div_done) state_d = ST_FIX;
         ST_FIX: if (flush_hit) begin
            state_d = ST_IDLE;
         end else begin
            if (op_q[1]) result_d = rneg_q ? -div_rem : div_rem;
            else         result_d = qneg_q ? -div_quo : div_quo;
            state_d = ST_RESP;
         end
         // A completing handshake and a matching flush both just retire the op.
         ST_RESP: if (rsp_ready || flush_hit) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_q     <= '0;
         hart_q   <= '0;
         rd_q     <= '0;
         cnt_q    <= '0;
         prod_q   <= '0;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         hart_q   <= hart_d;
         rd_q     <= rd_d;
         cnt_q    <= cnt_d;
         prod_q   <= prod_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         result_q <= result_d;
      end
   end

   muldiv_div_core #(.XLEN(XLEN)) u_div (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (div_start),
      .abort     (flush_hit && state_q != ST_IDLE),
      .dividend  (mag_a),
      .divisor   (mag_b),
      .quotient  (div_quo),
      .remainder (div_rem),
      .done      (div_done)
   );

   assign req_ready   = (state_q == ST_IDLE);
   assign busy        = (state_q != ST_IDLE);
   assign rsp_valid   = (state_q == ST_RESP);
   assign rsp_result  = result_q;
   assign rsp_hart_id = hart_q;
   assign rsp_rd      = rd_q;

endmodule

// File: tb/tb_muldiv_iter_unit.sv
// Directed bench for muldiv_iter_unit: vector table for op results and latencies,
// plus hand sequences for backpressure, flush and reset corner cases.
module tb_muldiv_iter_unit;
   import muldiv_pkg::*;

   localparam int XLEN = 32;
   localparam int HW   = 2;
   localparam int RW   = 5;
   localparam int ML   = 4;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            req_valid, req_ready;
   logic [2:0]      req_op;
   logic [XLEN-1:0] req_a, req_b;
   logic [HW-1:0]   req_hart_id;
   logic [RW-1:0]   req_rd;
   logic            flush_valid;
   logic [HW-1:0]   flush_hart_id;
   logic            rsp_valid, rsp_ready;
   logic [XLEN-1:0] rsp_result;
   logic [HW-1:0]   rsp_hart_id;
   logic [RW-1:0]   rsp_rd;
   logic            busy;

   muldiv_iter_unit #(
      .XLEN(XLEN), .HART_ID_W(HW), .REG_ADDR_W(RW), .MUL_LATENCY(ML)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_hart_id(req_hart_id), .req_rd(req_rd),
      .flush_valid(flush_valid), .flush_hart_id(flush_hart_id),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
      .rsp_hart_id(rsp_hart_id), .rsp_rd(rsp_rd), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] exp;
      int          lat;
   } vec_t;

   vec_t vecs[23];
   int   n_pass  = 0;
   int   n_total = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [HW-1:0] hart, input logic [RW-1:0] rd);
      req_op      = op;
      req_a       = a;
      req_b       = b;
      req_hart_id = hart;
      req_rd      = rd;
      req_valid   = 1'b1;
      tick();
      req_valid   = 1'b0;
   endtask

   // Latency counted in cycles after the accept edge; gives up at 100.
   task automatic wait_rsp(output int lat);
      lat = 1;
      while (!rsp_valid && lat < 100) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      int lat;
      logic seen;

      vecs[0]  = '{OP_MUL,    32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 4};
      vecs[1]  = '{OP_MULH,   32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 4};
      vecs[2]  = '{OP_MULHU,  32'd7,        32'hFFFFFFFD, 32'h00000006, 4};
      vecs[3]  = '{OP_MULHSU, 32'd7,        32'hFFFFFFFD, 32'h00000006, 4};
      vecs[4]  = '{OP_MULHSU, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, 4};
      vecs[5]  = '{OP_MULHU,  32'hFFFFFFFF, 32'd2,        32'h00000001, 4};
      vecs[6]  = '{OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 4};
      vecs[7]  = '{OP_DIV,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34};
      vecs[8]  = '{OP_REM,    32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34};
      vecs[9]  = '{OP_DIVU,   32'd100,      32'd7,        32'd14,       34};
      vecs[10] = '{OP_REMU,   32'd100,      32'd7,        32'd2,        34};
      vecs[11] = '{OP_DIV,    32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34};
      vecs[12] = '{OP_REM,    32'd7,        32'hFFFFFFFE, 32'd1,        34};
      vecs[13] = '{OP_DIV,    32'd5,        32'd0,        32'hFFFFFFFF, 1};
      vecs[14] = '{OP_REMU,   32'h1234,     32'd0,        32'h1234,     1};
      vecs[15] = '{OP_DIVU,   32'd9,        32'd0,        32'hFFFFFFFF, 1};
      vecs[16] = '{OP_REM,    32'd5,        32'd0,        32'd5,        1};
      vecs[17] = '{OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1};
      vecs[18] = '{OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        1};
      vecs[19] = '{OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'd0,        34};
      vecs[20] = '{OP_REMU,   32'h80000000, 32'hFFFFFFFF, 32'h80000000, 34};
      vecs[21] = '{OP_DIVU,   32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 34};
      vecs[22] = '{OP_DIV,    32'h80000000, 32'd2,        32'hC0000000, 34};

      rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
      req_hart_id = '0; req_rd = '0; flush_valid = 1'b0; flush_hart_id = '0;
      rsp_ready = 1'b1;
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_busy",      32'(busy),      32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_result",    rsp_result,     32'd0);
      chk("rst_tags",      32'({rsp_hart_id, rsp_rd}), 32'd0);
      tick(); tick();
      rst_n = 1'b1;
      tick();

      for (int i = 0; i < 23; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, HW'(i % 4), RW'(i + 1));
         wait_rsp(lat);
         chk($sformatf("v%0d_result", i),  rsp_result, vecs[i].exp);
         chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
         chk($sformatf("v%0d_hart", i),    32'(rsp_hart_id), 32'(i % 4));
         chk($sformatf("v%0d_rd", i),      32'(rsp_rd), 32'(i + 1));
         tick();
         chk($sformatf("v%0d_idle", i),    32'(req_ready && !rsp_valid), 32'd1);
      end

      // Backpressure: response held for five cycles, then released.
      rsp_ready = 1'b0;
      issue(OP_MUL, 32'd3, 32'd5, 2'd3, 5'd17);
      wait_rsp(lat);
      for (int k = 0; k < 5; k++) begin
         chk("bp_valid",  32'(rsp_valid), 32'd1);
         chk("bp_result", rsp_result, 32'd15);
         chk("bp_tags",   32'({rsp_hart_id, rsp_rd}), 32'({2'd3, 5'd17}));
         chk("bp_ready_busy", 32'({req_ready, busy}), 32'b01);
         tick();
      end
      rsp_ready = 1'b1;
      tick();
      chk("bp_release", 32'({req_ready, rsp_valid}), 32'b10);

      // Matching flush while the response is stalled discards it.
      rsp_ready = 1'b0;
      issue(OP_MULHU, 32'd9, 32'd9, 2'd0, 5'd3);
      wait_rsp(lat);
      chk("fresp_valid", 32'(rsp_valid), 32'd1);
      flush_valid = 1'b1; flush_hart_id = 2'd0;
      tick();
      flush_valid = 1'b0; rsp_ready = 1'b1;
      chk("fresp_drop", 32'({req_ready, rsp_valid}), 32'b10);

      // Flush hart 2 at T+10 of its divide.
      issue(OP_DIVU, 32'd100, 32'd7, 2'd2, 5'd9);
      for (int k = 0; k < 9; k++) tick();
      flush_valid = 1'b1; flush_hart_id = 2'd2;
      tick();
      flush_valid = 1'b0;
      chk("fdiv_ready", 32'({req_ready, busy}), 32'b10);
      seen = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (rsp_valid) seen = 1'b1;
         tick();
      end
      chk("fdiv_no_rsp", 32'(seen), 32'd0);

      // Flush of a different hart leaves the op alone.
      issue(OP_DIV, 32'hFFFFFFF9, 32'd2, 2'd2, 5'd4);
      for (int k = 0; k < 4; k++) tick();
      flush_valid = 1'b1; flush_hart_id = 2'd1;
      tick();
      flush_valid = 1'b0;
      wait_rsp(lat);
      chk("fother_result",  rsp_result, 32'hFFFFFFFD);
      chk("fother_latency", 32'(lat + 5), 32'd34);
      tick();

      // Same-hart flush and request in IDLE: request dropped.
      flush_valid = 1'b1; flush_hart_id = 2'd1;
      issue(OP_MUL, 32'd2, 32'd2, 2'd1, 5'd6);
      flush_valid = 1'b0;
      chk("drop_idle", 32'({req_ready, busy}), 32'b10);
      seen = 1'b0;
      for (int k = 0; k < 6; k++) begin
         if (rsp_valid || busy) seen = 1'b1;
         tick();
      end
      chk("drop_no_rsp", 32'(seen), 32'd0);

      // Reset in the middle of a divide.
      issue(OP_DIVU, 32'd1000, 32'd3, 2'd3, 5'd30);
      for (int k = 0; k < 10; k++) tick();
      chk("rmid_busy", 32'(busy), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("rmid_ctrl",   32'({req_ready, busy, rsp_valid}), 32'b100);
      chk("rmid_result", rsp_result, 32'd0);
      chk("rmid_tags",   32'({rsp_hart_id, rsp_rd}), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      issue(OP_MUL, 32'd7, 32'hFFFFFFFD, 2'd1, 5'd2);
      wait_rsp(lat);
      chk("rpost_result",  rsp_result, 32'hFFFFFFEB);
      chk("rpost_latency", 32'(lat), 32'd4);
      chk("rpost_tags",    32'({rsp_hart_id, rsp_rd}), 32'({2'd1, 5'd2}));
      tick();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
